// File: rtl/linen_buffer.sv
// -----------------------------------------------------------------------------
// linen_buffer
// Line buffer for the Canny front end. It keeps the NL-1 most recent lines of the
// current frame in a ring of line RAMs. For every accepted pixel it emits an
// NL-pixel vertical column.
//
// Features
//   - Warm-up border fill while the window is not yet vertically full:
//     zeros, or replication of the oldest row received so far.
//   - Per-line length tracking: a slice that belongs to a shorter, earlier line
//     reads as zero past that line's end.
//   - Sticky overflow flag for lines longer than 2**AW pixels.
//
// Ports
//   clk         pixel clock
//   rst_b       asynchronous active-low reset
//   vvalid      frame valid
//   hvalid      pixel valid (honoured only while vvalid=1)
//   din         input pixel
//   border_rep  warm-up fill select (0 zeros, 1 replicate); sampled at vvalid rise
//   fsync       vvalid delayed by 2 cycles
//   hsync       column valid, aligned with dout
//   dout        column: slice 0 = current row, slice k = row (current-k)
//   ini_row     window not vertically full for this column
//   ini_column  first column of a line
//   ovf         sticky line-overflow flag, cleared at vvalid rise
//
// Pipeline: cycle 0 accept/RAM read, cycle 1 RAM read register, cycle 2 output register.
// -----------------------------------------------------------------------------
module linen_buffer #(
    parameter int DW = 8,
    parameter int AW = 11,
    parameter int NL = 3
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             vvalid,
    input  logic             hvalid,
    input  logic [DW-1:0]    din,
    input  logic             border_rep,
    output logic             fsync,
    output logic             hsync,
    output logic [NL*DW-1:0] dout,
    output logic             ini_row,
    output logic             ini_column,
    output logic             ovf
);

    localparam int NR   = NL - 1;
    localparam int MAXW = 2 ** AW;
    localparam int CW   = AW + 1;
    localparam int SW   = (NR > 1) ? $clog2(NR) : 1;
    localparam int RW   = $clog2(NL);

    // frame / line state
    logic          vvalid_d_r;
    logic          hvalid_d_r;
    logic [CW-1:0] col_cnt_r;
    logic [RW-1:0] row_cnt_r;
    logic [SW-1:0] wr_sel_r;
    logic [CW-1:0] len_r [NR];
    logic          border_r;
    logic          ovf_st_r;

    // line RAMs and their read registers
    logic [DW-1:0] mem_r     [NR][MAXW];
    logic [DW-1:0] rd_data_r [NR];

    // stage-1 context travelling alongside the RAM read
    logic [DW-1:0] din_p1_r;
    logic [RW-1:0] row_p1_r;
    logic [SW-1:0] sel_p1_r [NR];
    logic [NR-1:0] short_p1_r;
    logic          border_p1_r;
    logic          fs_p1_r;
    logic          hs_p1_r;
    logic          ir_p1_r;
    logic          ic_p1_r;

    // combinational
    logic          acc_s;
    logic          vrise_s;
    logic          vfall_s;
    logic          hfall_s;
    logic [CW-1:0] col_eff_s;
    logic [RW-1:0] row_eff_s;
    logic [SW-1:0] wr_sel_eff_s;
    logic          border_eff_s;
    logic          full_s;
    logic          wr_en_s;
    logic [AW-1:0] addr_s;
    logic [SW-1:0] sel_s [NR];
    logic [NR-1:0] short_s;
    logic [DW-1:0] col_val_s [NL];
    logic [NL*DW-1:0] dout_s;

    // Event detection. On a vvalid rise the frame state is treated as already
    // cleared, so a pixel arriving in that same cycle lands at row 0, column 0.
    always_comb begin
        acc_s   = vvalid & hvalid;
        vrise_s = vvalid & ~vvalid_d_r;
        vfall_s = ~vvalid & vvalid_d_r;
        hfall_s = ~hvalid & hvalid_d_r;
        if (vrise_s) begin
            col_eff_s    = '0;
            row_eff_s    = '0;
            wr_sel_eff_s = '0;
            border_eff_s = border_rep;
        end else begin
            col_eff_s    = col_cnt_r;
            row_eff_s    = row_cnt_r;
            wr_sel_eff_s = wr_sel_r;
            border_eff_s = border_r;
        end
        full_s  = (col_eff_s == CW'(MAXW));
        wr_en_s = acc_s & ~full_s;
        addr_s  = col_eff_s[AW-1:0];
    end

    // For each slice k, pick the ring RAM (wr_sel-k) mod (NL-1). Also flag
    // columns that lie beyond the length of the line stored there.
    always_comb begin
        int d;
        int idx;
        d       = 0;
        idx     = 0;
        short_s = '0;
        for (int k = 0; k < NR; k++) begin
            sel_s[k] = '0;
        end
        for (int k = 1; k < NL; k++) begin
            d = int'(wr_sel_eff_s) - k;
            if (d < 0) begin
                idx = d + NR;
            end else begin
                idx = d;
            end
            sel_s[k-1] = SW'(idx);
            if (vrise_s) begin
                short_s[k-1] = 1'b1;
            end else begin
                short_s[k-1] = (col_eff_s >= len_r[SW'(idx)]);
            end
        end
    end

    // Frame, line and ring bookkeeping.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            vvalid_d_r <= 1'b0;
            hvalid_d_r <= 1'b0;
            col_cnt_r  <= '0;
            row_cnt_r  <= '0;
            wr_sel_r   <= '0;
            border_r   <= 1'b0;
            ovf_st_r   <= 1'b0;
            for (int r = 0; r < NR; r++) begin
                len_r[r] <= '0;
            end
        end else begin
            vvalid_d_r <= vvalid;
            hvalid_d_r <= hvalid;
            if (vrise_s) begin
                row_cnt_r <= '0;
                wr_sel_r  <= '0;
                border_r  <= border_rep;
                ovf_st_r  <= 1'b0;
                for (int r = 0; r < NR; r++) begin
                    len_r[r] <= '0;
                end
                col_cnt_r <= wr_en_s ? CW'(1) : CW'(0);
            end else if (vfall_s) begin
                // Aborted line: its RAM contents are never read before the next
                // frame start clears the ring state.
                col_cnt_r <= '0;
            end else if (hfall_s) begin
                col_cnt_r <= '0;
                if (vvalid) begin
                    len_r[wr_sel_r] <= col_cnt_r;
                    if (wr_sel_r == SW'(NR - 1)) begin
                        wr_sel_r <= '0;
                    end else begin
                        wr_sel_r <= wr_sel_r + SW'(1);
                    end
                    if (row_cnt_r != RW'(NL - 1)) begin
                        row_cnt_r <= row_cnt_r + RW'(1);
                    end
                end
            end else if (wr_en_s) begin
                col_cnt_r <= col_cnt_r + CW'(1);
            end else if (acc_s) begin
                // accepted pixel with a full line: dropped, column held
                ovf_st_r <= 1'b1;
            end
        end
    end

    // Line RAMs: read-before-write at the current column. The RAM being written
    // therefore still returns the oldest row (slice NL-1).
    always_ff @(posedge clk) begin
        for (int j = 0; j < NR; j++) begin
            rd_data_r[j] <= mem_r[j][addr_s];
        end
        if (wr_en_s) begin
            mem_r[wr_sel_eff_s][addr_s] <= din;
        end
    end

    // Stage-1 register: context needed to assemble the column next cycle.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            din_p1_r    <= '0;
            row_p1_r    <= '0;
            short_p1_r  <= '0;
            border_p1_r <= 1'b0;
            fs_p1_r     <= 1'b0;
            hs_p1_r     <= 1'b0;
            ir_p1_r     <= 1'b0;
            ic_p1_r     <= 1'b0;
            for (int k = 0; k < NR; k++) begin
                sel_p1_r[k] <= '0;
            end
        end else begin
            din_p1_r    <= din;
            row_p1_r    <= row_eff_s;
            short_p1_r  <= short_s;
            border_p1_r <= border_eff_s;
            fs_p1_r     <= vvalid;
            hs_p1_r     <= wr_en_s;
            ir_p1_r     <= wr_en_s & (row_eff_s < RW'(NL - 1));
            ic_p1_r     <= wr_en_s & (col_eff_s == CW'(0));
            for (int k = 0; k < NR; k++) begin
                sel_p1_r[k] <= sel_s[k];
            end
        end
    end

    // Column assembly. Slices from rows not yet received this frame take the
    // border value: zero, or the oldest real slice (index row).
    always_comb begin
        col_val_s[0] = din_p1_r;
        for (int k = 1; k < NL; k++) begin
            if (short_p1_r[k-1]) begin
                col_val_s[k] = '0;
            end else begin
                col_val_s[k] = rd_data_r[sel_p1_r[k-1]];
            end
        end
        dout_s = '0;
        for (int k = 0; k < NL; k++) begin
            if (k > int'(row_p1_r)) begin
                if (border_p1_r) begin
                    dout_s[k*DW +: DW] = col_val_s[row_p1_r];
                end else begin
                    dout_s[k*DW +: DW] = '0;
                end
            end else begin
                dout_s[k*DW +: DW] = col_val_s[k];
            end
        end
    end

    // Output register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            fsync      <= 1'b0;
            hsync      <= 1'b0;
            dout       <= '0;
            ini_row    <= 1'b0;
            ini_column <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            fsync      <= fs_p1_r;
            hsync      <= hs_p1_r;
            dout       <= dout_s;
            ini_row    <= ir_p1_r;
            ini_column <= ic_p1_r;
            ovf        <= ovf_st_r;
        end
    end

endmodule
